// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one overlapping pattern detector across NCH bit-serial channels.
// Optional per-channel 8-bit match counters are built when SEQ_DET_SCHED_CNT_EN is defined.
`timescale 1ns/1ps
module seq_det_sched #(
  parameter int unsigned     NCH     = 4,
  parameter int unsigned     PLEN    = 5,
  parameter logic [PLEN-1:0] PATTERN = 5'b11011,
  localparam int unsigned    CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] bit_in,
  output logic [NCH-1:0] gnt,
  output logic           match_vld,
  output logic [CW-1:0]  match_ch
`ifdef SEQ_DET_SCHED_CNT_EN
  ,
  input  logic [CW-1:0]  cnt_sel,
  input  logic           cnt_clr,
  output logic [7:0]     cnt_out
`endif
);

  localparam int unsigned HW = PLEN - 1;
  localparam int unsigned FW = $clog2(PLEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(PLEN - 1);

  logic [CW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hist_q [NCH];
  logic [HW-1:0] hist_d [NCH];
  logic [FW-1:0] fill_q [NCH];
  logic [FW-1:0] fill_d [NCH];
  logic          match_vld_q, match_vld_d;
  logic [CW-1:0] match_ch_q, match_ch_d;

  logic          gnt_found;
  logic [CW-1:0] gnt_idx;
  logic [CW-1:0] cand;
  logic [PLEN-1:0] window;

  // Round-robin search starting at ptr; gated by reset and enable
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (rst && en) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        cand = CW'((32'(ptr_q) + k) % NCH);
        if (!gnt_found && req[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
    if (gnt_found) gnt[gnt_idx] = 1'b1;
  end

  // Shared engine: update the granted channel's history and test for a match
  always_comb begin
    ptr_d       = ptr_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_vld_d = 1'b0;
    match_ch_d  = match_ch_q;
    window      = {hist_q[gnt_idx], bit_in[gnt_idx]};
    if (gnt_found) begin
      ptr_d           = CW'((32'(gnt_idx) + 32'd1) % NCH);
      hist_d[gnt_idx] = HW'(window);
      if (fill_q[gnt_idx] != FILL_MAX) fill_d[gnt_idx] = fill_q[gnt_idx] + FW'(1);
      if ((fill_q[gnt_idx] == FILL_MAX) && (window == PATTERN)) begin
        match_vld_d = 1'b1;
        match_ch_d  = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q       <= '0;
      match_vld_q <= 1'b0;
      match_ch_q  <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      match_vld_q <= match_vld_d;
      match_ch_q  <= match_ch_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        hist_q[i] <= hist_d[i];
        fill_q[i] <= fill_d[i];
      end
    end
  end

  assign match_vld = match_vld_q;
  assign match_ch  = match_ch_q;

`ifdef SEQ_DET_SCHED_CNT_EN
  logic [7:0] cnt_q [NCH];
  logic [7:0] cnt_d [NCH];

  // Saturating match counters; clear wins over a same-edge increment
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      for (int unsigned i = 0; i < NCH; i++) cnt_d[i] = '0;
    end else if (match_vld_d && (cnt_q[gnt_idx] != 8'hFF)) begin
      cnt_d[gnt_idx] = cnt_q[gnt_idx] + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt_out = (32'(cnt_sel) < NCH) ? cnt_q[cnt_sel] : 8'd0;
`endif

endmodule
